// File: rtl/branch_predictor_unit.sv
// ---------------------------------------------------------------------------
// branch_predictor_unit
//
// Purpose:
//   Predicts the direction of conditional branches from a table of 2-bit
//   saturating counters indexed by the low bits of the branch address, and
//   emits the predicted next fetch address. Once execution of the pending
//   branch completes, the real outcome is resolved from W / CY, the counter
//   is trained, and a misprediction is flagged to the fetch stage together
//   with the architecturally correct next address.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   branch_valid          latched_branch holds a new instruction this cycle
//   latched_branch[21:0]  instruction word ([21:18] opcode, [10:0] target)
//   latched_branch_addr   address of that instruction
//   latched_W, latched_CY W register and carry flag at execution
//   latched_exec_done     the pending branch has finished executing
//   busy                  a branch is waiting to be resolved
//   pred_valid            1-cycle strobe qualifying pred_taken / pred_addr
//   pred_taken, pred_addr predicted direction and next fetch address
//   resolve_valid         1-cycle strobe qualifying mispredict/correct_addr
//   mispredict            prediction was wrong
//   correct_addr          real next fetch address
//   stat_branches,        (BP_STATS_EN only) saturating counts of resolved
//   stat_mispredicts       branches and of mispredicted branches
//
// Build options:
//   BP_STATS_EN  adds the two statistics counters and their output ports.
// ---------------------------------------------------------------------------
module branch_predictor_unit #(
   parameter int         INDEX_BITS = 6,
   parameter logic [1:0] CTR_INIT   = 2'b01
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        branch_valid,
   input  logic [21:0] latched_branch,
   input  logic [10:0] latched_branch_addr,
   input  logic [15:0] latched_W,
   input  logic        latched_CY,
   input  logic        latched_exec_done,
   output logic        busy,
   output logic        pred_valid,
   output logic        pred_taken,
   output logic [10:0] pred_addr,
   output logic        resolve_valid,
   output logic        mispredict,
`ifdef BP_STATS_EN
   output logic [15:0] stat_branches,
   output logic [15:0] stat_mispredicts,
`endif
   output logic [10:0] correct_addr
);

   localparam int DEPTH = 1 << INDEX_BITS;

   localparam logic [3:0] OP_JMP = 4'hA;
   localparam logic [3:0] OP_JZ  = 4'hB;
   localparam logic [3:0] OP_JNZ = 4'hC;
   localparam logic [3:0] OP_JC  = 4'hD;
   localparam logic [3:0] OP_JNC = 4'hE;

   typedef enum logic {IDLE, WAIT} state_t;

   state_t state;

   // Counter table; bit [1] of each entry is the predicted direction.
   logic [1:0] ctr [DEPTH];

   // Captured copy of the pending branch.
   logic [3:0]            op_q;
   logic [10:0]           target_q;
   logic [10:0]           addr_q;
   logic [INDEX_BITS-1:0] idx_q;

   // Instruction bits between opcode and target carry no meaning here.
   logic unused_bits;
   assign unused_bits = ^latched_branch[17:11];

   // Real branch outcome for a given opcode and execution flags.
   function automatic logic eval_taken(input logic [3:0]  op,
                                       input logic [15:0] w,
                                       input logic        cy);
      logic t;
      t = 1'b0;
      case (op)
         OP_JMP:  t = 1'b1;
         OP_JZ:   t = (w == 16'd0);
         OP_JNZ:  t = (w != 16'd0);
         OP_JC:   t = cy;
         OP_JNC:  t = ~cy;
         default: t = 1'b0;
      endcase
      return t;
   endfunction

   // ---- Prediction side (incoming instruction) ----
   logic [3:0]            new_op;
   logic                  new_is_branch;
   logic [INDEX_BITS-1:0] new_idx;
   logic                  new_taken;
   logic [10:0]           new_target;
   logic [10:0]           new_seq;
   logic                  accept;

   assign new_op        = latched_branch[21:18];
   assign new_is_branch = (new_op >= OP_JMP) && (new_op <= OP_JNC);
   assign new_idx       = latched_branch_addr[INDEX_BITS-1:0];
   assign new_target    = latched_branch[10:0];
   assign new_seq       = latched_branch_addr + 11'd1;   // wraps 0x7FF -> 0x000
   assign new_taken     = (new_op == OP_JMP) | ctr[new_idx][1];
   assign accept        = (state == IDLE) && branch_valid && new_is_branch;

   // ---- Resolution side (pending instruction) ----
   logic        act_taken;
   logic [10:0] seq_q;
   logic        is_jmp_q;
   logic        resolve_fire;
   logic        misp_now;

   assign act_taken    = eval_taken(op_q, latched_W, latched_CY);
   assign seq_q        = addr_q + 11'd1;
   assign is_jmp_q     = (op_q == OP_JMP);
   assign resolve_fire = (state == WAIT) && latched_exec_done;
   // pred_taken still holds the prediction made for the pending branch.
   assign misp_now     = !is_jmp_q && (act_taken != pred_taken);

   // ---- Main FSM, table and registered outputs ----
   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         busy          <= 1'b0;
         pred_valid    <= 1'b0;
         pred_taken    <= 1'b0;
         pred_addr     <= 11'd0;
         resolve_valid <= 1'b0;
         mispredict    <= 1'b0;
         correct_addr  <= 11'd0;
         op_q          <= 4'd0;
         target_q      <= 11'd0;
         addr_q        <= 11'd0;
         idx_q         <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ctr[i] <= CTR_INIT;
         end
      end else begin
         // Strobes drop unless re-asserted below.
         pred_valid    <= 1'b0;
         resolve_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (accept) begin
                  op_q       <= new_op;
                  target_q   <= new_target;
                  addr_q     <= latched_branch_addr;
                  idx_q      <= new_idx;
                  pred_valid <= 1'b1;
                  pred_taken <= new_taken;
                  pred_addr  <= new_taken ? new_target : new_seq;
                  busy       <= 1'b1;
                  state      <= WAIT;
               end
            end

            WAIT: begin
               // New branches are not accepted here; upstream re-presents.
               if (resolve_fire) begin
                  resolve_valid <= 1'b1;
                  correct_addr  <= act_taken ? target_q : seq_q;
                  mispredict    <= misp_now;
                  // Unconditional jumps never train the table.
                  if (!is_jmp_q) begin
                     if (act_taken) begin
                        if (ctr[idx_q] != 2'b11) ctr[idx_q] <= ctr[idx_q] + 2'd1;
                     end else begin
                        if (ctr[idx_q] != 2'b00) ctr[idx_q] <= ctr[idx_q] - 2'd1;
                     end
                  end
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end

            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef BP_STATS_EN
   // ---- Saturating statistics counters ----
   always_ff @(posedge clock) begin
      if (reset) begin
         stat_branches    <= 16'd0;
         stat_mispredicts <= 16'd0;
      end else if (resolve_fire) begin
         if (stat_branches != 16'hFFFF) stat_branches <= stat_branches + 16'd1;
         if (misp_now && (stat_mispredicts != 16'hFFFF))
            stat_mispredicts <= stat_mispredicts + 16'd1;
      end
   end
`endif

endmodule

// File: doc/branch_predictor_unit.md
Name: branch_predictor_unit

Overview:
- Consumes the registered branch instruction, its address, W, CY and exec_done from the predictor input latch.
- Predicts taken/not-taken from a table of 2-bit saturating counters indexed by the branch address, and emits the predicted next fetch address.
- After execution completes, resolves the real outcome from W/CY, updates the table, and flags mispredictions to the fetch stage.

Parameters:
INDEX_BITS, 6, table index width taken from latched_branch_addr[INDEX_BITS-1:0]; table depth = 2**INDEX_BITS.
CTR_INIT, 2'b01, counter value loaded into every entry on reset (weakly not-taken).

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
branch_valid  input  1  latched_branch holds a new instruction this cycle.
latched_branch  input  22  instruction word; [21:18] opcode, [10:0] jump target.
latched_branch_addr  input  11  address of the instruction.
latched_W  input  16  W register value at execution.
latched_CY  input  1  carry flag at execution.
latched_exec_done  input  1  execution of the pending branch has completed.
busy  output  1  a branch is pending resolution.
pred_valid  output  1  one-cycle strobe: prediction outputs are valid.
pred_taken  output  1  predicted direction.
pred_addr  output  11  predicted next fetch address.
resolve_valid  output  1  one-cycle strobe: resolution outputs are valid.
mispredict  output  1  the prediction was wrong (qualified by resolve_valid).
correct_addr  output  11  architecturally correct next address.

Behaviour:
- Opcode decode (latched_branch[21:18]):
  - 4'hA JMP: always taken.
  - 4'hB JZ: taken when W == 0.
  - 4'hC JNZ: taken when W != 0.
  - 4'hD JC: taken when CY = 1.
  - 4'hE JNC: taken when CY = 0.
  - Any other opcode is a non-branch.
- Reset:
  - All outputs go to 0.
  - State goes to IDLE.
  - Every counter is loaded with CTR_INIT in the same cycle.
  - Reset asserted while in WAIT discards the pending branch; no resolve strobe is issued.
- State machine has two states, IDLE and WAIT.
- IDLE:
  - On branch_valid with a branch opcode:
    - Capture opcode, target and addr; idx = addr[INDEX_BITS-1:0].
    - pred_taken = 1 for JMP; otherwise pred_taken = ctr[idx][1].
    - pred_addr = target if taken, else addr + 1 (11-bit, wraps 0x7FF to 0x000).
    - pred_valid = 1 for exactly one cycle, on the clock edge after capture (latency 1).
    - Go to WAIT; busy = 1 from that same edge.
  - branch_valid with a non-branch opcode: ignored, no outputs change.
  - latched_exec_done while IDLE: ignored.
- WAIT:
  - Evaluate taken from the opcode using latched_W / latched_CY in the cycle where latched_exec_done = 1.
  - On the next edge:
    - resolve_valid = 1 for one cycle.
    - correct_addr = target if taken, else addr + 1.
    - mispredict = (actual != pred_taken).
    - Counter update: taken increments, saturating at 2'b11; not-taken decrements, saturating at 2'b00.
    - JMP does not update the table and never mispredicts.
    - Return to IDLE; busy = 0.
  - branch_valid while in WAIT, including the cycle where exec_done = 1: ignored. Upstream must hold or re-present the branch after busy drops.
- A new branch may be accepted in the cycle immediately after resolve_valid; it uses the counter value just written.
- Outputs other than strobes hold their last value until overwritten.

Optional Feature:
- Macro: BP_STATS_EN.
- When defined:
  - Adds outputs stat_branches [15:0] and stat_mispredicts [15:0].
  - stat_branches increments on each resolve_valid; stat_mispredicts increments on each resolve_valid with mispredict = 1.
  - Both counters saturate at 16'hFFFF and clear on reset.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then JZ: addr 0x010, target 0x200, W = 0.
  - pred_valid: pred_taken = 0, pred_addr = 0x011.
  - After exec_done: resolve_valid, mispredict = 1, correct_addr = 0x200; ctr[0x10] = 2'b10.
- Repeat the same JZ at 0x010 with W = 0.
  - Prediction: pred_taken = 1, pred_addr = 0x200.
  - Resolution: mispredict = 0; ctr[0x10] = 2'b11.
  - Issue a third taken branch at the same index: ctr stays at 2'b11.
- JMP: addr 0x7FF, target 0x005.
  - pred_taken = 1, pred_addr = 0x005; resolution gives mispredict = 0; table unchanged.
- JNC: addr 0x7FF, CY = 1 (not taken).
  - pred_addr = 0x000 (wrap); correct_addr = 0x000; mispredict = 0; ctr[0x3F] = 2'b00.
- Overlap and idle cases:
  - branch_valid asserted during WAIT together with exec_done: only the pending branch resolves, the new one is ignored.
  - exec_done while IDLE: no strobes.
- Reset asserted while in WAIT:
  - busy = 0 and no resolve_valid.
  - A subsequent branch predicts from CTR_INIT.
  - With BP_STATS_EN defined, the stat counters read 0.
